// File: rtl/encoder_layer_0_attention_self_value_weight_sink.sv
// Value-weight sink: captures a valid/ready stream of weight beats into an
// on-chip RAM at incrementing addresses, flags full once the tensor is in,
// and serves ce-gated readback with 2-cycle latency.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   data_in[]       weight elements of one beat (unpacked, PRECISION_0 each)
//   data_in_valid   beat valid
//   data_in_ready   sink can accept a beat (decoded from state)
//   load_start      single-cycle pulse, (re)starts a fill at address 0
//   full            all IN_DEPTH beats captured
//   wr_count        beats accepted in the current fill
//   rd_addr, rd_ce  read word address and read clock enable
//   rd_q            read data, 2 cycles after the address with rd_ce=1
module encoder_layer_0_attention_self_value_weight_sink #(
    parameter int unsigned VALUE_WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned VALUE_WEIGHT_TENSOR_SIZE_DIM_1 = 1,
    parameter int unsigned VALUE_WEIGHT_PRECISION_0       = 16,
    parameter int unsigned VALUE_WEIGHT_PRECISION_1       = 3,
    parameter int unsigned VALUE_WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int unsigned VALUE_WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int unsigned IN_DEPTH =
        (VALUE_WEIGHT_TENSOR_SIZE_DIM_0 * VALUE_WEIGHT_TENSOR_SIZE_DIM_1) /
        (VALUE_WEIGHT_PARALLELISM_DIM_0 * VALUE_WEIGHT_PARALLELISM_DIM_1),
    parameter int unsigned BEAT_WIDTH =
        VALUE_WEIGHT_PRECISION_0 * VALUE_WEIGHT_PARALLELISM_DIM_0 * VALUE_WEIGHT_PARALLELISM_DIM_1,
    parameter int unsigned AWIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [VALUE_WEIGHT_PRECISION_0-1:0] data_in [0:VALUE_WEIGHT_PARALLELISM_DIM_0*VALUE_WEIGHT_PARALLELISM_DIM_1-1],
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    input  logic                                load_start,
    output logic                                full,
    output logic [AWIDTH-1:0]                   wr_count,
    input  logic [AWIDTH-1:0]                   rd_addr,
    input  logic                                rd_ce,
    output logic [BEAT_WIDTH-1:0]               rd_q
);

    localparam int unsigned N_ELEM    = VALUE_WEIGHT_PARALLELISM_DIM_0 * VALUE_WEIGHT_PARALLELISM_DIM_1;
    localparam int unsigned ELEM_W    = VALUE_WEIGHT_PRECISION_0;
    localparam int unsigned RAM_AW    = $clog2(IN_DEPTH);
    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AWIDTH-1:0]     r_wr_count;
    logic [AWIDTH-1:0]     w_wr_count_nxt;
    logic                  w_we;
    logic [BEAT_WIDTH-1:0] w_beat;
    logic [BEAT_WIDTH-1:0] r_mem [0:RAM_WORDS-1];
    logic [BEAT_WIDTH-1:0] r_stage0;
    logic [BEAT_WIDTH-1:0] r_rd_q;
    logic                  w_unused;

    // Pack element j into bits [ELEM_W*j +: ELEM_W]; inverse of the source's unpack.
    for (genvar j = 0; j < N_ELEM; j++) begin : g_pack
        assign w_beat[ELEM_W*j +: ELEM_W] = data_in[j];
    end

    // State and fill-count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_count <= w_wr_count_nxt;
        end
    end

    // Next-state, count and write-enable decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_count_nxt = r_wr_count;
        w_we           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt    = S_FILL;
                    w_wr_count_nxt = '0;
                end
            end
            S_FILL: begin
                // A restart wins over a concurrent beat, which is dropped.
                if (load_start) begin
                    w_wr_count_nxt = '0;
                end else if (data_in_valid) begin
                    w_we           = rst;
                    w_wr_count_nxt = r_wr_count + AWIDTH'(1);
                    if (r_wr_count == AWIDTH'(IN_DEPTH - 1)) begin
                        w_state_nxt = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (load_start) begin
                    w_state_nxt    = S_FILL;
                    w_wr_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wr_count_nxt = '0;
            end
        endcase
    end

    // Weight RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_count[RAM_AW-1:0]] <= w_beat;
        end
    end

    // Two-stage ce-gated read pipeline; read-first against a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stage0 <= '0;
            r_rd_q   <= '0;
        end else if (rd_ce) begin
            r_stage0 <= r_mem[rd_addr[RAM_AW-1:0]];
            r_rd_q   <= r_stage0;
        end
    end

    assign data_in_ready = (r_state == S_FILL);
    assign full          = (r_state == S_FULL);
    assign wr_count      = r_wr_count;
    assign rd_q          = r_rd_q;

    // Out-of-range address bits and the fractional-bit count have no function here.
    assign w_unused = ^{rd_addr[AWIDTH-1:RAM_AW], 1'(VALUE_WEIGHT_PRECISION_1)};

endmodule

// File: tb/tb_encoder_layer_0_attention_self_value_weight_sink.sv
// Self-checking bench for the value-weight sink: reference RAM model in the
// bench, read-expectation scoreboard queue, one task per scenario.
module tb_encoder_layer_0_attention_self_value_weight_sink;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 6;

    logic        clk;
    logic        rst;
    logic [15:0] data_in [0:0];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        load_start;
    logic        full;
    logic [AW-1:0] wr_count;
    logic [AW-1:0] rd_addr;
    logic        rd_ce;
    logic [15:0] rd_q;

    logic [15:0] model [0:DEPTH-1];
    logic [15:0] sb_q [$];
    int          exp_cnt;
    int          pass_cnt;
    int          total_cnt;

    encoder_layer_0_attention_self_value_weight_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .load_start    (load_start),
        .full          (full),
        .wr_count      (wr_count),
        .rd_addr       (rd_addr),
        .rd_ce         (rd_ce),
        .rd_q          (rd_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        exp_cnt = 0;
        total_cnt++;
        if (wr_count !== AW'(0) || data_in_ready !== 1'b1 || full !== 1'b0) begin
            $display("FAIL load_start: wr_count=%0d ready=%b full=%b, want 0/1/0", wr_count, data_in_ready, full);
        end else pass_cnt++;
    endtask

    // Stream n beats base+k; toggle inserts an idle cycle between beats.
    task automatic send_beats(input logic [15:0] base, input int n, input bit toggle);
        int sent = 0;
        int cyc  = 0;
        bit v;
        while (sent < n) begin
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            data_in[0]    = base + 16'(sent);
            data_in_valid = v;
            total_cnt++;
            if (data_in_ready !== 1'b1 || full !== 1'b0 || wr_count !== AW'(exp_cnt)) begin
                $display("FAIL fill_cycle %0d: ready=%b full=%b wr_count=%0d, want 1/0/%0d",
                         cyc, data_in_ready, full, wr_count, exp_cnt);
            end else pass_cnt++;
            if (v) begin
                model[exp_cnt] = base + 16'(sent);
                exp_cnt++;
                sent++;
            end
            cyc++;
            step();
        end
        data_in_valid = 1'b0;
        total_cnt++;
        if (exp_cnt == int'(DEPTH)) begin
            if (full !== 1'b1 || data_in_ready !== 1'b0 || wr_count !== AW'(DEPTH)) begin
                $display("FAIL fill_done: full=%b ready=%b wr_count=%0d, want 1/0/%0d",
                         full, data_in_ready, wr_count, DEPTH);
            end else pass_cnt++;
        end else begin
            if (full !== 1'b0 || data_in_ready !== 1'b1 || wr_count !== AW'(exp_cnt)) begin
                $display("FAIL fill_partial: full=%b ready=%b wr_count=%0d, want 0/1/%0d",
                         full, data_in_ready, wr_count, exp_cnt);
            end else pass_cnt++;
        end
    endtask

    // Single read: push expectation, wait the two-cycle latency, pop and compare.
    task automatic read_one(input int a, input string tag);
        logic [15:0] exp_v;
        rd_addr = AW'(a);
        rd_ce   = 1'b1;
        sb_q.push_back(model[a]);
        step();
        step();
        rd_ce = 1'b0;
        exp_v = sb_q.pop_front();
        total_cnt++;
        if (rd_q !== exp_v) begin
            $display("FAIL %s addr %0d: rd_q=%h, want %h", tag, a, rd_q, exp_v);
        end else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_in[0]    = 16'($urandom);
            data_in_valid = 1'($urandom);
            load_start    = 1'($urandom);
            rd_ce         = 1'($urandom);
            rd_addr       = AW'($urandom_range(0, DEPTH - 1));
            step();
            total_cnt++;
            if (data_in_ready !== 1'b0 || full !== 1'b0 || wr_count !== AW'(0) || rd_q !== 16'h0000) begin
                $display("FAIL reset cycle %0d: ready=%b full=%b wr_count=%0d rd_q=%h, want 0/0/0/0000",
                         c, data_in_ready, full, wr_count, rd_q);
            end else pass_cnt++;
        end
        data_in_valid = 1'b0;
        load_start    = 1'b0;
        rd_ce         = 1'b0;
        rst           = 1'b1;
        // IDLE must ignore a valid beat.
        data_in_valid = 1'b1;
        data_in[0]    = 16'hAAAA;
        step();
        data_in_valid = 1'b0;
        total_cnt++;
        if (data_in_ready !== 1'b0 || wr_count !== AW'(0) || full !== 1'b0) begin
            $display("FAIL idle_ignore: ready=%b wr_count=%0d full=%b, want 0/0/0", data_in_ready, wr_count, full);
        end else pass_cnt++;
        exp_v = 16'h0000;
        total_cnt++;
        if (rd_q !== exp_v) begin
            $display("FAIL idle_rd_q: rd_q=%h, want %h", rd_q, exp_v);
        end else pass_cnt++;
    endtask

    task automatic test_continuous_fill();
        pulse_load();
        send_beats(16'h0100, DEPTH, 1'b0);
        read_one(5, "cont_read");
        total_cnt++;
        if (rd_q !== 16'h0105) begin
            $display("FAIL cont_read_const: rd_q=%h, want 0105", rd_q);
        end else pass_cnt++;
    endtask

    // Toggled fill then back-to-back pipelined readback of every address.
    task automatic test_toggle_fill_back_to_back();
        logic [15:0] exp_v;
        pulse_load();
        send_beats(16'h0100, DEPTH, 1'b1);
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            if (i >= 2) begin
                exp_v = sb_q.pop_front();
                total_cnt++;
                if (rd_q !== exp_v) begin
                    $display("FAIL b2b_read addr %0d: rd_q=%h, want %h", i - 2, rd_q, exp_v);
                end else pass_cnt++;
            end
            rd_ce = 1'b1;
            if (i < int'(DEPTH)) begin
                rd_addr = AW'(i);
                sb_q.push_back(model[i]);
            end else begin
                rd_addr = AW'(0);
            end
            step();
        end
        rd_ce = 1'b0;
    endtask

    task automatic test_hold_after_full();
        data_in[0]    = 16'hDEAD;
        data_in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total_cnt++;
            if (data_in_ready !== 1'b0 || full !== 1'b1 || wr_count !== AW'(DEPTH)) begin
                $display("FAIL full_hold cycle %0d: ready=%b full=%b wr_count=%0d, want 0/1/%0d",
                         c, data_in_ready, full, wr_count, DEPTH);
            end else pass_cnt++;
        end
        data_in_valid = 1'b0;
        read_one(0, "full_hold_read");
        total_cnt++;
        if (rd_q !== 16'h0100) begin
            $display("FAIL full_hold_const: rd_q=%h, want 0100", rd_q);
        end else pass_cnt++;
    endtask

    task automatic test_reload_abort();
        pulse_load();
        send_beats(16'h2000, 10, 1'b0);
        // Restart concurrent with a beat: the beat must be dropped.
        load_start    = 1'b1;
        data_in_valid = 1'b1;
        data_in[0]    = 16'hBEEF;
        total_cnt++;
        if (data_in_ready !== 1'b1) begin
            $display("FAIL abort_ready: ready=%b, want 1", data_in_ready);
        end else pass_cnt++;
        step();
        load_start    = 1'b0;
        data_in_valid = 1'b0;
        exp_cnt       = 0;
        total_cnt++;
        if (wr_count !== AW'(0) || full !== 1'b0 || data_in_ready !== 1'b1) begin
            $display("FAIL abort_restart: wr_count=%0d full=%b ready=%b, want 0/0/1", wr_count, full, data_in_ready);
        end else pass_cnt++;
        read_one(10, "abort_discard");
        send_beats(16'h3000, DEPTH, 1'b0);
        read_one(0, "reload_read");
        total_cnt++;
        if (rd_q !== 16'h3000) begin
            $display("FAIL reload_const: rd_q=%h, want 3000", rd_q);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill_and_freeze();
        pulse_load();
        send_beats(16'h4000, 7, 1'b0);
        rst = 1'b0;
        step();
        total_cnt++;
        if (data_in_ready !== 1'b0 || wr_count !== AW'(0) || full !== 1'b0 || rd_q !== 16'h0000) begin
            $display("FAIL mid_reset: ready=%b wr_count=%0d full=%b rd_q=%h, want 0/0/0/0000",
                     data_in_ready, wr_count, full, rd_q);
        end else pass_cnt++;
        rst = 1'b1;
        step();
        exp_cnt = 0;
        total_cnt++;
        if (data_in_ready !== 1'b0 || wr_count !== AW'(0)) begin
            $display("FAIL post_reset_idle: ready=%b wr_count=%0d, want 0/0", data_in_ready, wr_count);
        end else pass_cnt++;
        read_one(6, "kept_word");
        total_cnt++;
        if (rd_q !== 16'h4006) begin
            $display("FAIL kept_word_const: rd_q=%h, want 4006", rd_q);
        end else pass_cnt++;
        rd_ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            rd_addr = AW'(c);
            step();
            total_cnt++;
            if (rd_q !== model[6]) begin
                $display("FAIL ce_freeze cycle %0d: rd_q=%h, want %h", c, rd_q, model[6]);
            end else pass_cnt++;
        end
    endtask

    initial begin
        rst           = 1'b0;
        data_in[0]    = 16'h0000;
        data_in_valid = 1'b0;
        load_start    = 1'b0;
        rd_addr       = '0;
        rd_ce         = 1'b0;
        exp_cnt       = 0;
        pass_cnt      = 0;
        total_cnt     = 0;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 16'h0000;

        test_reset();
        test_continuous_fill();
        test_toggle_fill_back_to_back();
        test_hold_after_full();
        test_reload_abort();
        test_reset_mid_fill_and_freeze();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
